// File: rtl/enemy_pkg.sv
// Shared types and default constants for the enemy scheduler and its arbiter.
package enemy_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DYING = 2'd1,
    DEAD  = 2'd2
  } enemy_state_t;

  localparam int ENEMY_N_DEFAULT         = 4;
  localparam int ENEMY_HP_MAX_DEFAULT    = 3;
  localparam int ENEMY_DEATH_FRAMES_DEF  = 8;
  localparam int ENEMY_RESPAWN_FRAMES_DEF = 60;
  localparam int ENEMY_COOLDOWN_DEF      = 30;

  // Width of a frame counter able to hold the largest of the frame parameters.
  function automatic int frame_cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; the search starts one past the last granted index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop; a path that
    // leaves one unassigned would infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  // NOTE: non-blocking so the pointer samples pre-edge values like every other flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= IDW'(N - 1);
    end else if (grant_valid) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/enemy_scheduler.sv
// Enemy life/HP tracking, knockback strobes and frame-rate attack arbitration.
// Optional macro ENEMY_RESPAWN_EN: DEAD enemies return to ALIVE after RESPAWN_FRAMES ticks.
module enemy_scheduler
  import enemy_pkg::*;
#(
  parameter int N_ENEMY         = ENEMY_N_DEFAULT,
  parameter int HP_MAX          = ENEMY_HP_MAX_DEFAULT,
  parameter int DEATH_FRAMES    = ENEMY_DEATH_FRAMES_DEF,
  parameter int RESPAWN_FRAMES  = ENEMY_RESPAWN_FRAMES_DEF,
  parameter int ATTACK_COOLDOWN = ENEMY_COOLDOWN_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               game_frame_clk_rising_edge,
  input  logic [N_ENEMY-1:0] Enemy_Hit,
  input  logic [N_ENEMY-1:0] Enemy_Attack_Ready,
  output logic [N_ENEMY-1:0] is_alive,
  output logic [N_ENEMY-1:0] Enemy_Is_Attacked,
  output logic               Player_Damage,
  output logic [2:0]         Attack_Grant_Id,
  output logic [7:0]         Kill_Count
);

  localparam int HPW = $clog2(HP_MAX) + 1;
  localparam int CW  = frame_cnt_width(DEATH_FRAMES, RESPAWN_FRAMES, ATTACK_COOLDOWN);
  localparam int IDW = $clog2(N_ENEMY);

  enemy_state_t       state     [N_ENEMY];
  logic [HPW-1:0]     hp        [N_ENEMY];
  logic [CW-1:0]      frame_cnt [N_ENEMY];
  logic [N_ENEMY-1:0] pend;
  logic [N_ENEMY-1:0] hit_now;
  logic [N_ENEMY-1:0] req;
  logic [CW-1:0]      cooldown;
  logic [3:0]         kills;
  logic [8:0]         kill_sum;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  // A hit arriving on the tick cycle itself is consumed together with any pending one.
  always_comb begin
    hit_now = '0;
    req     = '0;
    kills   = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      hit_now[i] = (state[i] == ALIVE) && (pend[i] || Enemy_Hit[i]);
      req[i]     = (state[i] == ALIVE) && Enemy_Attack_Ready[i] && !hit_now[i];
      if (hit_now[i] && hp[i] <= HPW'(1)) kills = kills + 4'd1;
    end
  end

  assign kill_sum = {1'b0, Kill_Count} + 9'(kills);

  // Counters act on their post-decrement value: a grant is allowed on the tick that would reach 0.
  rr_arbiter #(
    .N   (N_ENEMY),
    .IDW (IDW)
  ) u_arbiter (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .en          (game_frame_clk_rising_edge && (cooldown <= CW'(1))),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the per-enemy arrays hold live game state, so every entry is reset, not just control bits.
      for (int i = 0; i < N_ENEMY; i++) begin
        state[i]     <= ALIVE;
        hp[i]        <= HPW'(HP_MAX);
        frame_cnt[i] <= '0;
      end
      pend              <= '0;
      is_alive          <= '1;
      Enemy_Is_Attacked <= '0;
      cooldown          <= '0;
      Player_Damage     <= 1'b0;
      Attack_Grant_Id   <= '0;
      Kill_Count        <= '0;
    end else begin
      Player_Damage <= 1'b0;
      if (!game_frame_clk_rising_edge) begin
        for (int i = 0; i < N_ENEMY; i++) begin
          if (state[i] == ALIVE && Enemy_Hit[i]) pend[i] <= 1'b1;
        end
      end else begin
        Enemy_Is_Attacked <= hit_now;
        for (int i = 0; i < N_ENEMY; i++) begin
          case (state[i])
            ALIVE: begin
              if (hit_now[i]) begin
                pend[i] <= 1'b0;
                if (hp[i] > HPW'(1)) begin
                  hp[i] <= hp[i] - HPW'(1);
                end else begin
                  state[i]     <= DYING;
                  frame_cnt[i] <= CW'(DEATH_FRAMES);
                end
              end
            end
            DYING: begin
              if (frame_cnt[i] <= CW'(1)) begin
                state[i]    <= DEAD;
                is_alive[i] <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
                frame_cnt[i] <= CW'(RESPAWN_FRAMES);
`endif
              end else begin
                frame_cnt[i] <= frame_cnt[i] - CW'(1);
              end
            end
            DEAD: begin
`ifdef ENEMY_RESPAWN_EN
              if (frame_cnt[i] <= CW'(1)) begin
                state[i]    <= ALIVE;
                is_alive[i] <= 1'b1;
                hp[i]       <= HPW'(HP_MAX);
                pend[i]     <= 1'b0;
              end else begin
                frame_cnt[i] <= frame_cnt[i] - CW'(1);
              end
`endif
            end
            default: state[i] <= ALIVE;
          endcase
        end
        Kill_Count <= kill_sum[8] ? 8'hFF : kill_sum[7:0];
        if (grant_valid) begin
          Player_Damage   <= 1'b1;
          Attack_Grant_Id <= 3'(grant_id);
          cooldown        <= CW'(ATTACK_COOLDOWN);
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler: per-cycle model comparison plus directed literal checks.
module tb_enemy_scheduler;

  localparam int N   = 4;
  localparam int HPM = 3;
  localparam int DF  = 8;
  localparam int RF  = 60;
  localparam int AC  = 30;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         game_frame_clk_rising_edge = 1'b0;
  logic [N-1:0] Enemy_Hit = '0;
  logic [N-1:0] Enemy_Attack_Ready = '0;
  logic [N-1:0] is_alive;
  logic [N-1:0] Enemy_Is_Attacked;
  logic         Player_Damage;
  logic [2:0]   Attack_Grant_Id;
  logic [7:0]   Kill_Count;

  int compared   = 0;
  int mismatched = 0;
  int pd_count   = 0;

  always #10 Clk = ~Clk;

  enemy_scheduler #(
    .N_ENEMY         (N),
    .HP_MAX          (HPM),
    .DEATH_FRAMES    (DF),
    .RESPAWN_FRAMES  (RF),
    .ATTACK_COOLDOWN (AC)
  ) dut (
    .Clk                        (Clk),
    .Reset                      (Reset),
    .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
    .Enemy_Hit                  (Enemy_Hit),
    .Enemy_Attack_Ready         (Enemy_Attack_Ready),
    .is_alive                   (is_alive),
    .Enemy_Is_Attacked          (Enemy_Is_Attacked),
    .Player_Damage              (Player_Damage),
    .Attack_Grant_Id            (Attack_Grant_Id),
    .Kill_Count                 (Kill_Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Life: 0 = alive, 1 = dying, 2 = dead. Timers count frames remaining in the phase.
  int  m_life [N];
  int  m_hp   [N];
  int  m_left [N];
  bit  m_pend [N];
  bit  m_att  [N];
  bit  m_hit  [N];
  int  m_since;
  int  m_last;
  int  m_kills;
  int  m_gid;
  bit  m_pd;
  bit  m_valid = 1'b0;

  task automatic model_step();
    bit granted;
    int g;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        m_life[i] = 0; m_hp[i] = HPM; m_left[i] = 0; m_pend[i] = 0; m_att[i] = 0;
      end
      m_since = AC; m_last = N - 1; m_kills = 0; m_gid = 0; m_pd = 0; m_valid = 1'b1;
      return;
    end
    m_pd = 0;
    if (!game_frame_clk_rising_edge) begin
      for (int i = 0; i < N; i++) if (m_life[i] == 0 && Enemy_Hit[i]) m_pend[i] = 1;
      return;
    end
    for (int i = 0; i < N; i++) m_hit[i] = (m_life[i] == 0) && (m_pend[i] || Enemy_Hit[i]);
    if (m_since < 100000) m_since++;
    granted = 0;
    g = 0;
    if (m_since >= AC) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (!granted && m_life[j] == 0 && Enemy_Attack_Ready[j] && !m_hit[j]) begin
          granted = 1; g = j;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_att[i] = m_hit[i];
      if (m_life[i] == 0) begin
        if (m_hit[i]) begin
          m_pend[i] = 0;
          if (m_hp[i] > 1) m_hp[i]--;
          else begin
            m_life[i] = 1; m_left[i] = DF;
            if (m_kills < 255) m_kills++;
          end
        end
      end else if (m_life[i] == 1) begin
        m_left[i]--;
        if (m_left[i] <= 0) begin m_life[i] = 2; m_left[i] = RF; end
      end else begin
`ifdef ENEMY_RESPAWN_EN
        m_left[i]--;
        if (m_left[i] <= 0) begin m_life[i] = 0; m_hp[i] = HPM; m_pend[i] = 0; end
`endif
      end
    end
    if (granted) begin
      m_pd = 1; m_gid = g; m_last = g; m_since = 0;
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Compare every cycle, away from the clock edge.
  initial forever begin
    logic [N-1:0] e_alive, e_att;
    @(posedge Clk);
    #2;
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        e_alive[i] = (m_life[i] != 2);
        e_att[i]   = m_att[i];
      end
      check("is_alive", 32'(is_alive), 32'(e_alive));
      check("Enemy_Is_Attacked", 32'(Enemy_Is_Attacked), 32'(e_att));
      check("Player_Damage", 32'(Player_Damage), 32'(m_pd));
      check("Attack_Grant_Id", 32'(Attack_Grant_Id), 32'(m_gid));
      check("Kill_Count", 32'(Kill_Count), 32'(m_kills));
      if (Player_Damage === 1'b1) pd_count++;
    end
  end

  // ---------------- stimulus ----------------
  logic         pd_after;
  logic [2:0]   gid_after;
  logic [N-1:0] att_after;
  logic [N-1:0] alive_after;
  logic [7:0]   kc_after;

  task automatic frame();
    @(negedge Clk) game_frame_clk_rising_edge = 1'b1;
    @(negedge Clk) game_frame_clk_rising_edge = 1'b0;
    pd_after    = Player_Damage;
    gid_after   = Attack_Grant_Id;
    att_after   = Enemy_Is_Attacked;
    alive_after = is_alive;
    kc_after    = Kill_Count;
    repeat (2) @(negedge Clk);
  endtask

  task automatic hit_pulse(input int i);
    @(negedge Clk) Enemy_Hit[i] = 1'b1;
    @(negedge Clk) Enemy_Hit[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int pd_base;
    do_reset();
    check("reset is_alive", 32'(is_alive), 32'hF);
    check("reset Kill_Count", 32'(Kill_Count), 32'd0);
    check("reset Enemy_Is_Attacked", 32'(Enemy_Is_Attacked), 32'd0);
    check("reset Attack_Grant_Id", 32'(Attack_Grant_Id), 32'd0);

    // Idle: no requests, no damage for 100 ticks.
    pd_base = pd_count;
    repeat (100) frame();
    check("idle damage pulses", 32'(pd_count - pd_base), 32'd0);

    // Enemy 2: three hits one per frame, each strobe held for one frame.
    for (int h = 1; h <= 2; h++) begin
      hit_pulse(2);
      frame();
      check("hit strobe on", 32'(att_after[2]), 32'd1);
      frame();
      check("hit strobe off", 32'(att_after[2]), 32'd0);
    end
    hit_pulse(2);
    frame();
    check("kill strobe", 32'(att_after[2]), 32'd1);
    check("kill count 1", 32'(kc_after), 32'd1);
    check("dying still alive", 32'(alive_after[2]), 32'd1);
    repeat (7) frame();
    check("dying after 7", 32'(alive_after[2]), 32'd1);
    frame();
    check("dead after 8", 32'(alive_after[2]), 32'd0);
`ifdef ENEMY_RESPAWN_EN
    repeat (59) frame();
    check("dead after 59", 32'(alive_after[2]), 32'd0);
    frame();
    check("respawned after 60", 32'(alive_after[2]), 32'd1);
`else
    repeat (70) frame();
    check("dead stays dead", 32'(alive_after[2]), 32'd0);
`endif

    // Enemy 1: five pulses in one frame cost exactly one hp.
    repeat (5) hit_pulse(1);
    frame();
    check("multi-hit no kill", 32'(kc_after), 32'd1);
    hit_pulse(1);
    frame();
    check("second hit no kill", 32'(kc_after), 32'd1);
    hit_pulse(1);
    frame();
    check("third hit kills", 32'(kc_after), 32'd2);
    hit_pulse(1);
    frame();
    check("dying hit discarded", 32'(att_after[1]), 32'd0);
    frame();
    check("mid dying alive", 32'(alive_after[1]), 32'd1);

    // Reset while enemy 1 is DYING.
    do_reset();
    check("reset mid-dying alive", 32'(is_alive), 32'hF);
    check("reset mid-dying kills", 32'(Kill_Count), 32'd0);

    // Round-robin grants with cooldown.
    Enemy_Attack_Ready = 4'hF;
    pd_base = pd_count;
    for (int f = 1; f <= 121; f++) begin
      frame();
      if ((f - 1) % 30 == 0) begin
        check("grant pulse", 32'(pd_after), 32'd1);
        check("grant id", 32'(gid_after), 32'(((f - 1) / 30) % 4));
      end
    end
    check("grant pulse total", 32'(pd_count - pd_base), 32'd5);
    Enemy_Attack_Ready = '0;

    // Killing hit on enemy 0 and requests from 0 and 1 on the same tick.
    do_reset();
    hit_pulse(0);
    frame();
    hit_pulse(0);
    frame();
    Enemy_Attack_Ready = 4'b0011;
    hit_pulse(0);
    frame();
    check("collide grant", 32'(pd_after), 32'd1);
    check("collide grant id", 32'(gid_after), 32'd1);
    check("collide strobe", 32'(att_after[0]), 32'd1);
    check("collide kill", 32'(kc_after), 32'd1);
    Enemy_Attack_Ready = '0;
    repeat (8) frame();
    check("collide enemy dead", 32'(alive_after[0]), 32'd0);

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
